// File: rtl/data_mem_pkg.sv
// Shared encodings for the MEM-stage data memory responder: FSM states and
// the m_size / m_rw field values.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // A word access must sit on a 4-byte boundary; byte accesses never misalign.
    function automatic logic is_misaligned(logic size, logic [1:0] lsb);
        return (size == SIZE_WORD) && (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressed, big-endian data array with byte or word write lanes and an
// asynchronous read of the addressed byte or aligned word.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned Depth = 256,
    parameter int unsigned Aw    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          size_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [7:0]    mem_q [Depth];
    logic [Aw-1:0] lane_addr [4];

    // Word lanes ignore addr[1:0]; lane 0 is the most significant byte.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = (addr_i & ~Aw'(3)) | Aw'(i);
        end
    end

    always_comb begin
        if (size_i == SIZE_BYTE) begin
            rdata_o = {24'h00_0000, mem_q[addr_i]};
        end else begin
            rdata_o = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                       mem_q[lane_addr[2]], mem_q[lane_addr[3]]};
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (size_i == SIZE_BYTE) begin
                mem_q[addr_i] <= wdata_i[7:0];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    mem_q[lane_addr[i]] <= wdata_i[31-8*i -: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder with programmable latency and pipeline stall.
// Define DATA_MEM_ALIGN_TRAP_EN to suppress/zero misaligned word accesses and flag misalign.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_enable_i,
    input  logic        m_rw_i,
    input  logic        m_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam logic [3:0] LatCnt = 4'(LATENCY);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          rw_q;
    logic          size_q;
    logic [31:0]   data_out_q;
    logic          done_q;

    logic          accept;
    logic          enter_done;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          req_rw;
    logic          req_size;
    logic          drop;
    logic          mem_we;
    logic [31:0]   rdata;
    logic [31:0]   load_val;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr_i[31:AW];

    // With zero latency the access completes straight from IDLE, so the live
    // inputs rather than the latched copies drive the array on that edge.
    always_comb begin
        accept     = rst_n && (state_q == StIdle) && m_enable_i;
        enter_done = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));
        if (state_q == StIdle) begin
            req_addr = addr_i[AW-1:0];
            req_data = data_in_i;
            req_rw   = m_rw_i;
            req_size = m_size_i;
        end else begin
            req_addr = addr_q;
            req_data = wdata_q;
            req_rw   = rw_q;
            req_size = size_q;
        end
    end

`ifdef DATA_MEM_ALIGN_TRAP_EN
    logic mis_q;

    assign drop       = is_misaligned(req_size, req_addr[1:0]);
    assign misalign_o = mis_q;
`else
    assign drop       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign mem_we     = enter_done && (req_rw == RW_WRITE) && !drop;
    assign load_val   = drop ? 32'h0000_0000 : rdata;
    assign stall_o    = accept || (state_q == StWait);
    assign done_o     = done_q;
    assign data_out_o = data_out_q;

    data_mem_array #(
        .Depth (DEPTH),
        .Aw    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .size_i  (req_size),
        .addr_i  (req_addr),
        .wdata_i (req_data),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            rw_q       <= RW_READ;
            size_q     <= SIZE_WORD;
            data_out_q <= 32'h0000_0000;
            done_q     <= 1'b0;
`ifdef DATA_MEM_ALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            done_q <= enter_done;
            if (enter_done && (req_rw == RW_READ)) begin
                data_out_q <= load_val;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_data;
                        rw_q    <= req_rw;
                        size_q  <= req_size;
                        cnt_q   <= LatCnt;
                        state_q <= (LATENCY == 0) ? StDone : StWait;
`ifdef DATA_MEM_ALIGN_TRAP_EN
                        mis_q   <= drop;
`endif
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
`ifdef DATA_MEM_ALIGN_TRAP_EN
                    mis_q   <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=0,
// checked every cycle against a byte-array model plus hand-computed literals.
module tb_data_mem_responder;

`ifdef DATA_MEM_ALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en   [2];
    logic        rw   [2];
    logic        sz   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        stall[2];
    logic        done [2];
    logic        mis  [2];

    logic [7:0]  mem_m     [2][256];
    logic [31:0] exp_dout  [2];
    logic        exp_stall [2];
    logic        exp_done  [2];
    logic        exp_mis   [2];
    bit          chk_en = 1'b0;
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2), .AW(8)) u_dut_l2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_enable_i (en[0]),
        .m_rw_i     (rw[0]),
        .m_size_i   (sz[0]),
        .addr_i     (addr[0]),
        .data_in_i  (din[0]),
        .data_out_o (dout[0]),
        .stall_o    (stall[0]),
        .done_o     (done[0]),
        .misalign_o (mis[0])
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0), .AW(8)) u_dut_l0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_enable_i (en[1]),
        .m_rw_i     (rw[1]),
        .m_size_i   (sz[1]),
        .addr_i     (addr[1]),
        .data_in_i  (din[1]),
        .data_out_o (dout[1]),
        .stall_o    (stall[1]),
        .done_o     (done[1]),
        .misalign_o (mis[1])
    );

    task automatic cmp(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s dut%0d t=%0t: got %h, want %h", name, i, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                cmp("stall", i, {31'b0, stall[i]}, {31'b0, exp_stall[i]});
                cmp("done", i, {31'b0, done[i]}, {31'b0, exp_done[i]});
                cmp("misalign", i, {31'b0, mis[i]}, {31'b0, exp_mis[i]});
                cmp("data_out", i, dout[i], exp_dout[i]);
            end
        end
    end

    function automatic logic [31:0] model_load(input int i, input logic size,
                                               input logic [31:0] a);
        logic [7:0] b;
        logic [7:0] base;
        b    = a[7:0];
        base = {b[7:2], 2'b00};
        if (size == 1'b1) return {24'h0, mem_m[i][b]};
        if (Trap && b[1:0] != 2'b00) return 32'h0;
        return {mem_m[i][base], mem_m[i][base + 8'd1], mem_m[i][base + 8'd2],
                mem_m[i][base + 8'd3]};
    endfunction

    task automatic model_store(input int i, input logic size, input logic [31:0] a,
                               input logic [31:0] d);
        logic [7:0] b;
        logic [7:0] base;
        b    = a[7:0];
        base = {b[7:2], 2'b00};
        if (size == 1'b1) begin
            mem_m[i][b] = d[7:0];
        end else if (!(Trap && b[1:0] != 2'b00)) begin
            for (int j = 0; j < 4; j++) mem_m[i][base + 8'(j)] = d[31-8*j -: 8];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input int j);
        en[j]        = 1'b0;
        exp_stall[j] = 1'b0;
        exp_done[j]  = 1'b0;
        exp_mis[j]   = 1'b0;
    endtask

    task automatic idle_all(input int n);
        repeat (n) begin
            step();
            set_idle(0);
            set_idle(1);
        end
    endtask

    // Request is held through the done cycle, as the pipeline would hold it.
    task automatic access(input int i, input logic w, input logic size,
                          input logic [31:0] a, input logic [31:0] d);
        int          lat;
        logic        flag;
        logic [31:0] ld;
        lat  = (i == 0) ? 2 : 0;
        flag = Trap && size == 1'b0 && a[1:0] != 2'b00;
        ld   = model_load(i, size, a);
        for (int k = 0; k <= lat + 1; k++) begin
            step();
            set_idle(1 - i);
            en[i]        = 1'b1;
            rw[i]        = w;
            sz[i]        = size;
            addr[i]      = a;
            din[i]       = d;
            exp_stall[i] = (k <= lat);
            exp_done[i]  = (k == lat + 1);
            exp_mis[i]   = flag && (k >= 1);
            if (k == lat + 1 && w == 1'b0) exp_dout[i] = ld;
        end
        if (w == 1'b1) model_store(i, size, a, d);
    endtask

    task automatic lit(input string name, input int i, input logic [31:0] want);
        idle_all(1);
        cmp(name, i, dout[i], want);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i]       = 1'b0;
            rw[i]       = 1'b0;
            sz[i]       = 1'b0;
            addr[i]     = 32'h0;
            din[i]      = 32'h0;
            exp_dout[i] = 32'h0;
            set_idle(i);
        end
        chk_en = 1'b1;

        // Reset, then quiet idle.
        repeat (3) step();
        rst_n = 1'b1;
        idle_all(10);
        cmp("reset_dout", 0, dout[0], 32'h0);
        cmp("reset_dout", 1, dout[1], 32'h0);

        // Word store and big-endian byte readback.
        access(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        lit("byte10", 0, 32'h0000_00DE);
        access(0, 1'b0, 1'b1, 32'h0000_0011, 32'h0);
        lit("byte11", 0, 32'h0000_00AD);
        access(0, 1'b0, 1'b1, 32'h0000_0012, 32'h0);
        lit("byte12", 0, 32'h0000_00BE);
        access(0, 1'b0, 1'b1, 32'h0000_0013, 32'h0);
        lit("byte13", 0, 32'h0000_00EF);

        // Byte store touches one lane only; store leaves data_out alone.
        access(0, 1'b1, 1'b1, 32'h0000_0012, 32'hFFFF_FF55);
        lit("after_store", 0, 32'h0000_00EF);
        access(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        lit("word10", 0, 32'hDEAD_55EF);

        // Address wrap plus misaligned word load.
        access(0, 1'b0, 1'b0, 32'h0000_0113, 32'h0);
        lit("wrap_load", 0, Trap ? 32'h0 : 32'hDEAD_55EF);

        // Misaligned word store: aligns silently, or is suppressed under trap.
        access(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0102_0304);
        access(0, 1'b1, 1'b0, 32'h0000_0033, 32'hA5A5_A5A5);
        access(0, 1'b0, 1'b0, 32'h0000_0030, 32'h0);
        lit("mis_store", 0, Trap ? 32'h0102_0304 : 32'hA5A5_A5A5);

        // Reset during WAIT aborts the store.
        access(0, 1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
        step();
        set_idle(1);
        en[0] = 1'b1; rw[0] = 1'b1; sz[0] = 1'b0; addr[0] = 32'h20; din[0] = 32'h1234_5678;
        exp_stall[0] = 1'b1; exp_done[0] = 1'b0; exp_mis[0] = 1'b0;
        step();
        exp_stall[0] = 1'b1;
        step();
        rst_n = 1'b0;
        set_idle(0);
        set_idle(1);
        exp_dout[0] = 32'h0;
        exp_dout[1] = 32'h0;
        idle_all(2);
        rst_n = 1'b1;
        idle_all(4);
        access(0, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
        lit("abort_store", 0, 32'hCAFE_F00D);

        // Zero latency, back-to-back requests.
        access(1, 1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344);
        access(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        access(1, 1'b1, 1'b1, 32'h0000_0041, 32'h0000_0099);
        access(1, 1'b0, 1'b1, 32'h0000_0041, 32'h0);
        access(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        lit("b2b_word", 1, 32'h1199_3344);
        access(1, 1'b0, 1'b1, 32'h0000_0043, 32'h0);
        lit("b2b_byte", 1, 32'h0000_0044);
        idle_all(3);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
